// File: rtl/wb_commit_if.sv
// ----------------------------------------------------------------------------
// wb_commit_if : bundle of the ALU, load, decode-check and RF-write signals
//                that pass between the pipeline and the writeback/commit unit
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface wb_commit_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_issue;
  logic [4:0]      ld_issue_rd;

  logic            ld_rsp_valid;
  logic [4:0]      ld_rsp_rd;
  logic [XLEN-1:0] ld_rsp_data;
  logic [2:0]      ld_rsp_funct3;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            stall;

  logic            regwrite;
  logic [4:0]      writereg;
  logic [XLEN-1:0] writedata;

  // Pipeline side: offers results, issues loads, observes stall and RF write.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_rsp_valid, ld_rsp_rd, ld_rsp_data, ld_rsp_funct3,
    output rs1, rs2,
    input  alu_ready, stall, regwrite, writereg, writedata
  );

  // Commit unit side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_rsp_valid, ld_rsp_rd, ld_rsp_data, ld_rsp_funct3,
    input  rs1, rs2,
    output alu_ready, stall, regwrite, writereg, writedata
  );
endinterface

`default_nettype wire

// File: rtl/wb_commit_unit.sv
// ----------------------------------------------------------------------------
// wb_commit_unit : merges ALU results and load responses into the single RF
//                  write port; keeps a pending-load scoreboard for RAW stalls
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_commit_unit #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  wb_commit_if.slave            bus,
  output logic                  sb_err_o,
  output logic [CNT_W-1:0]      commit_count_o
);

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  logic            buf_valid_q, buf_valid_d;
  logic [4:0]      buf_rd_q,    buf_rd_d;
  logic [XLEN-1:0] buf_data_q,  buf_data_d;
  logic [NREG-1:0] pend_q,      pend_d;
  logic            regwrite_q,  regwrite_d;
  logic [4:0]      writereg_q,  writereg_d;
  logic [XLEN-1:0] writedata_q, writedata_d;
  logic            sb_err_q,    sb_err_d;
  logic [CNT_W-1:0] count_q,    count_d;

  logic            w_alu_ready;
  logic            w_alu_acc;
  logic            w_win_valid;
  logic [4:0]      w_win_rd;
  logic [XLEN-1:0] w_win_data;
  logic            w_waw_err;
  logic            w_orphan_err;

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3)
      c_F3_LB:  r = {{(XLEN-8){d[7]}},   d[7:0]};
      c_F3_LBU: r = {{(XLEN-8){1'b0}},   d[7:0]};
      c_F3_LH:  r = {{(XLEN-16){d[15]}}, d[15:0]};
      c_F3_LHU: r = {{(XLEN-16){1'b0}},  d[15:0]};
      default:  r = d;
    endcase
    return r;
  endfunction

  // Held in reset the unit refuses ALU results so nothing is lost on release.
  assign w_alu_ready = rst & ~buf_valid_q;
  assign w_alu_acc   = bus.alu_valid & w_alu_ready;

  assign bus.alu_ready = w_alu_ready;
  assign bus.stall     = ((bus.rs1 != 5'd0) & pend_q[bus.rs1]) |
                         ((bus.rs2 != 5'd0) & pend_q[bus.rs2]);
  assign bus.regwrite  = regwrite_q;
  assign bus.writereg  = writereg_q;
  assign bus.writedata = writedata_q;
  assign sb_err_o       = sb_err_q;
  assign commit_count_o = count_q;

  // A same-cycle response to the register being re-issued retires the old
  // load, so the new issue is legal rather than a WAW collision.
  assign w_waw_err = bus.ld_issue & (bus.ld_issue_rd != 5'd0) &
                     pend_q[bus.ld_issue_rd] &
                     ~(bus.ld_rsp_valid & (bus.ld_rsp_rd == bus.ld_issue_rd));
  assign w_orphan_err = bus.ld_rsp_valid & (bus.ld_rsp_rd != 5'd0) &
                        ~pend_q[bus.ld_rsp_rd];

  always_comb begin
    w_win_valid = 1'b0;
    w_win_rd    = 5'd0;
    w_win_data  = '0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;

    if (bus.ld_rsp_valid) begin
      w_win_valid = 1'b1;
      w_win_rd    = bus.ld_rsp_rd;
      w_win_data  = load_extend(bus.ld_rsp_funct3, bus.ld_rsp_data);
      if (w_alu_acc) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = bus.alu_rd;
        buf_data_d  = bus.alu_data;
      end
    end else if (buf_valid_q) begin
      w_win_valid = 1'b1;
      w_win_rd    = buf_rd_q;
      w_win_data  = buf_data_q;
      buf_valid_d = 1'b0;
    end else if (w_alu_acc) begin
      w_win_valid = 1'b1;
      w_win_rd    = bus.alu_rd;
      w_win_data  = bus.alu_data;
    end
  end

  always_comb begin
    regwrite_d  = w_win_valid & (w_win_rd != 5'd0);
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    count_d     = count_q;
    if (w_win_valid) begin
      writereg_d  = w_win_rd;
      writedata_d = w_win_data;
    end
    if (regwrite_d) begin
      count_d = count_q + CNT_W'(1);
    end

    pend_d = pend_q;
    if (bus.ld_rsp_valid) begin
      pend_d[bus.ld_rsp_rd] = 1'b0;
    end
    if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) begin
      pend_d[bus.ld_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    sb_err_d = sb_err_q | w_waw_err | w_orphan_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= '0;
      pend_q      <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= '0;
      sb_err_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      pend_q      <= pend_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      sb_err_q    <= sb_err_d;
      count_q     <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// ----------------------------------------------------------------------------
// tb_wb_commit_unit : directed self-checking bench for wb_commit_unit
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_commit_unit;

  logic        clk;
  logic        rst;
  logic        sb_err;
  logic [31:0] commit_count;
  int          n_checks;
  int          n_fail;

  wb_commit_if #(.XLEN(32)) bus ();

  wb_commit_unit #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .sb_err_o       (sb_err),
    .commit_count_o (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = 5'd0;
    bus.alu_data      = 32'd0;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_rd   = 5'd0;
    bus.ld_rsp_valid  = 1'b0;
    bus.ld_rsp_rd     = 5'd0;
    bus.ld_rsp_data   = 32'd0;
    bus.ld_rsp_funct3 = 3'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.ld_issue    = 1'b1;
    bus.ld_issue_rd = rd;
    tick();
    bus.ld_issue    = 1'b0;
  endtask

  task automatic respond(input logic [4:0] rd, input logic [31:0] d,
                         input logic [2:0] f3);
    bus.ld_rsp_valid  = 1'b1;
    bus.ld_rsp_rd     = rd;
    bus.ld_rsp_data   = d;
    bus.ld_rsp_funct3 = f3;
  endtask

  // rd, raw data, funct3, expected extended value
  logic [4:0]  ext_rd  [5] = '{5'd10, 5'd15, 5'd16, 5'd17, 5'd18};
  logic [31:0] ext_raw [5] = '{32'h0001_8000, 32'h0000_01FF, 32'hDEAD_BEEF,
                               32'h0000_007F, 32'h1234_5678};
  logic [2:0]  ext_f3  [5] = '{3'b001, 3'b100, 3'b010, 3'b000, 3'b011};
  logic [31:0] ext_exp [5] = '{32'hFFFF_8000, 32'h0000_00FF, 32'hDEAD_BEEF,
                               32'h0000_007F, 32'h1234_5678};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    rst = 1'b0;
    tick();
    tick();
    check_eq("rst_regwrite", 32'(bus.regwrite), 32'd0);
    check_eq("rst_writereg", 32'(bus.writereg), 32'd0);
    check_eq("rst_writedata", bus.writedata, 32'd0);
    check_eq("rst_sb_err", 32'(sb_err), 32'd0);
    check_eq("rst_count", commit_count, 32'd0);
    check_eq("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("run_alu_ready", 32'(bus.alu_ready), 32'd1);

    // Plain ALU commit
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h1234;
    tick();
    idle();
    check_eq("alu_regwrite", 32'(bus.regwrite), 32'd1);
    check_eq("alu_writereg", 32'(bus.writereg), 32'd5);
    check_eq("alu_writedata", bus.writedata, 32'h1234);
    check_eq("alu_count", commit_count, 32'd1);

    // Load response collides with an ALU result: ALU goes through the buffer
    issue(5'd3);
    check_eq("issue_no_write", 32'(bus.regwrite), 32'd0);
    respond(5'd3, 32'h80, 3'b000);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 32'd7;
    tick();
    idle();
    check_eq("coll_ld_writereg", 32'(bus.writereg), 32'd3);
    check_eq("coll_ld_writedata", bus.writedata, 32'hFFFF_FF80);
    check_eq("coll_alu_ready0", 32'(bus.alu_ready), 32'd0);
    check_eq("coll_count1", commit_count, 32'd2);
    tick();
    check_eq("coll_buf_regwrite", 32'(bus.regwrite), 32'd1);
    check_eq("coll_buf_writereg", 32'(bus.writereg), 32'd4);
    check_eq("coll_buf_writedata", bus.writedata, 32'd7);
    check_eq("coll_alu_ready1", 32'(bus.alu_ready), 32'd1);
    check_eq("coll_count2", commit_count, 32'd3);
    check_eq("coll_sb_err", 32'(sb_err), 32'd0);

    // RAW stall on a pending load
    issue(5'd9);
    bus.rs1 = 5'd9;
    #1;
    check_eq("stall_pending", 32'(bus.stall), 32'd1);
    tick();
    check_eq("stall_held", 32'(bus.stall), 32'd1);
    respond(5'd9, 32'hABCD_8001, 3'b101);
    #1;
    check_eq("stall_rsp_cycle", 32'(bus.stall), 32'd1);
    tick();
    idle();
    check_eq("lhu_writereg", 32'(bus.writereg), 32'd9);
    check_eq("lhu_writedata", bus.writedata, 32'h0000_8001);
    check_eq("stall_cleared", 32'(bus.stall), 32'd0);
    check_eq("lhu_count", commit_count, 32'd4);

    // rd==0 write is suppressed
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hFFFF;
    bus.rs1       = 5'd0;
    tick();
    idle();
    check_eq("x0_regwrite", 32'(bus.regwrite), 32'd0);
    check_eq("x0_writedata", bus.writedata, 32'hFFFF);
    check_eq("x0_count", commit_count, 32'd4);
    check_eq("x0_no_stall", 32'(bus.stall), 32'd0);

    // Load extension variants
    for (int i = 0; i < 5; i++) begin
      issue(ext_rd[i]);
      respond(ext_rd[i], ext_raw[i], ext_f3[i]);
      tick();
      idle();
      check_eq($sformatf("ext%0d_writereg", i), 32'(bus.writereg), 32'(ext_rd[i]));
      check_eq($sformatf("ext%0d_writedata", i), bus.writedata, ext_exp[i]);
    end
    check_eq("ext_count", commit_count, 32'd9);

    // Issue and response to the same rd in one cycle: set wins, no error
    issue(5'd11);
    bus.ld_issue    = 1'b1;
    bus.ld_issue_rd = 5'd11;
    respond(5'd11, 32'd1, 3'b010);
    tick();
    idle();
    bus.rs1 = 5'd11;
    #1;
    check_eq("setwins_stall", 32'(bus.stall), 32'd1);
    check_eq("setwins_sb_err", 32'(sb_err), 32'd0);
    respond(5'd11, 32'd2, 3'b010);
    tick();
    idle();
    check_eq("setwins_cleared", 32'(bus.stall), 32'd0);
    check_eq("setwins_count", commit_count, 32'd11);
    check_eq("setwins_sb_err2", 32'(sb_err), 32'd0);

    // WAW issue -> sticky error; reset clears error and pending bits
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd7;
    issue(5'd7);
    issue(5'd7);
    check_eq("waw_sb_err", 32'(sb_err), 32'd1);
    check_eq("waw_stall", 32'(bus.stall), 32'd1);
    tick();
    check_eq("waw_sticky", 32'(sb_err), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_eq("waw_rst_sb_err", 32'(sb_err), 32'd0);
    check_eq("waw_rst_stall", 32'(bus.stall), 32'd0);
    check_eq("waw_rst_count", commit_count, 32'd0);

    // Response to a register never issued: error, but write still performed
    respond(5'd12, 32'h55AA, 3'b010);
    tick();
    idle();
    check_eq("orphan_sb_err", 32'(sb_err), 32'd1);
    check_eq("orphan_regwrite", 32'(bus.regwrite), 32'd1);
    check_eq("orphan_writereg", 32'(bus.writereg), 32'd12);
    check_eq("orphan_writedata", bus.writedata, 32'h55AA);

    // Reset while the skid buffer holds a result: it must be discarded
    bus.rs2 = 5'd0;
    issue(5'd13);
    respond(5'd13, 32'h1, 3'b010);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd14;
    bus.alu_data  = 32'h77;
    tick();
    idle();
    check_eq("bufrst_full", 32'(bus.alu_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("bufrst_ready_in_rst", 32'(bus.alu_ready), 32'd0);
    tick();
    check_eq("bufrst_regwrite", 32'(bus.regwrite), 32'd0);
    check_eq("bufrst_ready_after_edge", 32'(bus.alu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("bufrst_ready_release", 32'(bus.alu_ready), 32'd1);
    tick();
    check_eq("bufrst_no_write", 32'(bus.regwrite), 32'd0);
    check_eq("bufrst_writereg", 32'(bus.writereg), 32'd0);
    tick();
    check_eq("bufrst_no_write2", 32'(bus.regwrite), 32'd0);
    check_eq("bufrst_count", commit_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
